exec_alu_seq: RTL and testbench
===============================

Name: exec_alu_seq

Overview:
- RV32I execute stage that sits directly downstream of the operand builder.
- Consumes the A/B operand pair plus the opcode, funct3 and instr[30] fields, and produces a registered result through a valid/ready handshake.
- Add, sub, logic and compare ops complete in one cycle.
- Shifts use an iterative 1-bit-per-cycle shifter, which keeps area small.

Parameters:
- XLEN, 32: datapath width. Only 32 is supported.
- SHAMT_W, 5: width of the shift-amount field taken from B[SHAMT_W-1:0].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-low.
- in_valid  in  1  the A, B, opcode, funct3 and funct7_5 inputs are valid.
- in_ready  out  1  the unit can accept an operation.
- A  in  32  first operand, from the operand builder.
- B  in  32  second operand, from the operand builder.
- opcode  in  7  instruction opcode; the same value the operand builder receives as iflags.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- result  out  32  registered result.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state goes to IDLE.
  - result=0, out_valid=0, busy=0, in_ready=1 (in_ready follows the IDLE state).
  - Any operation in flight is discarded with no output.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE). An operation is accepted when in_valid && in_ready at a clk edge. Inputs are sampled only at acceptance; later changes to them are ignored.
- Operation decode, for opcode 0110011 (OP) and 0010011 (OP-IMM):
  - funct3 000: ADD. SUB only when opcode=OP and funct7_5=1. OP-IMM always adds.
  - 001: SLL.
  - 010: SLT (signed) → result {31'b0, A<B}.
  - 011: SLTU (unsigned) → result {31'b0, A<B}.
  - 100: XOR.
  - 101: SRL when funct7_5=0, SRA when funct7_5=1.
  - 110: OR.
  - 111: AND.
- Other opcodes:
  - 0110111 (LUI) and 0010111 (AUIPC): result = A+B.
  - Any other opcode: result = 0. It is still accepted and completes in 1 cycle.
- Arithmetic is modulo 2^32. Overflow is not flagged.
- Non-shift accept: IDLE→DONE. result is loaded at the accept edge and out_valid=1 from the next cycle, so latency is 1.
- Shift accept:
  - Load the working register with A and the counter with B[4:0]. The remaining bits of B are ignored.
  - If shamt=0: go straight to DONE with result=A (latency 1).
  - Else go to SHIFT. Each cycle shift by 1 position and decrement the counter:
    - SLL: zero-fill from the LSB.
    - SRL: zero-fill from the MSB.
    - SRA: replicate bit 31.
  - When the counter reaches 0 after a shift step, go to DONE. Latency from accept to out_valid is shamt+1 cycles; shamt=31 gives 32 cycles.
- DONE:
  - out_valid=1 and result is held stable until out_ready=1 at a clk edge.
  - That edge returns the state to IDLE with out_valid=0. result keeps its last value.
  - No accept is possible in the same cycle as the handoff, because in_ready=0 in DONE.
- out_ready is ignored outside DONE.
- in_valid is ignored outside IDLE. Upstream holds its operation until in_ready is high.
- busy=1 in SHIFT and DONE.

Optional Feature:
- Macro: EXEC_ALU_BARREL_SHIFT_EN.
- Defined: shifts use a combinational barrel shifter. Every operation goes IDLE→DONE with latency 1. The SHIFT state and the counter are not instantiated, and busy is high only in DONE.
- Undefined: iterative shifter exactly as in Behaviour.
- Results are identical in both builds; only the latency differs.

Test Plan:
- Reset: assert rst_n=0 while in SHIFT with 10 steps remaining, then release. Required: IDLE, out_valid=0, result=0, in_ready=1; no stale output appears afterwards.
- ADD/SUB:
  - OP, funct3=000, funct7_5=1, A=5, B=7 → result=0xFFFFFFFE, out_valid 1 cycle after accept.
  - OP-IMM with the same fields → result=12.
- SRA:
  - A=0x80000000, B=0x404 (shamt=4), funct3=101, funct7_5=1 → result=0xF8000000, out_valid exactly 5 cycles after accept (1 cycle with the macro defined).
  - Same test with funct7_5=0 (SRL) → result=0x08000000.
- Shift boundaries:
  - SLL with A=1, shamt=0 → result=1, latency 1.
  - SLL with A=1, shamt=31 → result=0x80000000, latency 32.
- Compare: A=0xFFFFFFFF, B=1.
  - SLT → result=1.
  - SLTU → result=0.
- Backpressure and misc:
  - Hold out_ready=0 for 4 cycles in DONE. result stays stable, in_ready=0 and in_valid is ignored. Raise out_ready; IDLE follows the next cycle.
  - LUI with A=0x12345000, B=0 → result=0x12345000.
  - opcode=0000011 → result=0.

Source files
------------

// File: rtl/exec_alu_seq_if.sv
// Handshake and operand bundle between the operand builder, the execute stage
// and its result consumer.
interface exec_alu_seq_if #(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_5;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   modport master (
      output in_valid, A, B, opcode, funct3, funct7_5, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, A, B, opcode, funct3, funct7_5, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/exec_alu_seq.sv
// RV32I execute stage: single-cycle ALU ops, shifts iterate one bit per cycle.
// Define EXEC_ALU_BARREL_SHIFT_EN to replace the iterative shifter with a barrel shifter.
module exec_alu_seq #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = 5
) (
   input logic           clk,
   input logic           rst_n,
   exec_alu_seq_if.slave bus
);
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};

`ifdef EXEC_ALU_BARREL_SHIFT_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
   localparam logic [1:0] SK_SLL = 2'd0;
   localparam logic [1:0] SK_SRL = 2'd1;
   localparam logic [1:0] SK_SRA = 2'd2;
   localparam logic [SHAMT_W-1:0] CNT_ZERO = {SHAMT_W{1'b0}};
   localparam logic [SHAMT_W-1:0] CNT_ONE  = {{(SHAMT_W-1){1'b0}}, 1'b1};

   logic               is_shift_s;
   logic [1:0]         kind_s;
   logic [1:0]         kind_r;
   logic [SHAMT_W-1:0] cnt_r;

   function automatic logic [XLEN-1:0] shift_step(input logic [XLEN-1:0] v, input logic [1:0] kind);
      case (kind)
         SK_SLL:  return {v[XLEN-2:0], 1'b0};
         SK_SRL:  return {1'b0, v[XLEN-1:1]};
         SK_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
         default: return v;
      endcase
   endfunction
`endif

   state_t             state_r;
   state_t             state_nxt_s;
   logic [XLEN-1:0]    result_r;
   logic [XLEN-1:0]    alu_res_s;
   logic               is_alu_s;
   logic [SHAMT_W-1:0] shamt_s;

   // Operation decode and single-cycle result; iterative shifts start from A.
   always_comb begin
      is_alu_s  = (bus.opcode == OPC_OP) || (bus.opcode == OPC_OP_IMM);
      shamt_s   = bus.B[SHAMT_W-1:0];
      alu_res_s = ZERO_X;
`ifndef EXEC_ALU_BARREL_SHIFT_EN
      is_shift_s = is_alu_s && ((bus.funct3 == 3'b001) || (bus.funct3 == 3'b101));
      if (bus.funct3 == 3'b101) begin
         kind_s = bus.funct7_5 ? SK_SRA : SK_SRL;
      end else begin
         kind_s = SK_SLL;
      end
`endif
      if (is_alu_s) begin
         case (bus.funct3)
            3'b000: begin
               if ((bus.opcode == OPC_OP) && bus.funct7_5) begin
                  alu_res_s = bus.A - bus.B;
               end else begin
                  alu_res_s = bus.A + bus.B;
               end
            end
`ifdef EXEC_ALU_BARREL_SHIFT_EN
            3'b001: alu_res_s = bus.A << shamt_s;
            3'b101: begin
               if (bus.funct7_5) begin
                  alu_res_s = $unsigned($signed(bus.A) >>> shamt_s);
               end else begin
                  alu_res_s = bus.A >> shamt_s;
               end
            end
`else
            3'b001:  alu_res_s = bus.A;
            3'b101:  alu_res_s = bus.A;
`endif
            3'b010:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            3'b011:  alu_res_s = {{(XLEN-1){1'b0}}, (bus.A < bus.B)};
            3'b100:  alu_res_s = bus.A ^ bus.B;
            3'b110:  alu_res_s = bus.A | bus.B;
            3'b111:  alu_res_s = bus.A & bus.B;
            default: alu_res_s = ZERO_X;
         endcase
      end else if ((bus.opcode == OPC_LUI) || (bus.opcode == OPC_AUIPC)) begin
         alu_res_s = bus.A + bus.B;
      end else begin
         alu_res_s = ZERO_X;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid) begin
`ifdef EXEC_ALU_BARREL_SHIFT_EN
               state_nxt_s = ST_DONE;
`else
               if (is_shift_s && (shamt_s != CNT_ZERO)) begin
                  state_nxt_s = ST_SHIFT;
               end else begin
                  state_nxt_s = ST_DONE;
               end
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
`ifndef EXEC_ALU_BARREL_SHIFT_EN
         ST_SHIFT: begin
            if (cnt_r == CNT_ONE) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_SHIFT;
            end
         end
`endif
         ST_DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake outputs follow the registered state.
   always_comb begin
      bus.in_ready  = (state_r == ST_IDLE);
      bus.out_valid = (state_r == ST_DONE);
      bus.busy      = (state_r != ST_IDLE);
      bus.result    = result_r;
   end

   // Result / working register, shift counter and shift kind.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_r <= ZERO_X;
`ifndef EXEC_ALU_BARREL_SHIFT_EN
         cnt_r    <= CNT_ZERO;
         kind_r   <= SK_SLL;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  result_r <= alu_res_s;
`ifndef EXEC_ALU_BARREL_SHIFT_EN
                  cnt_r    <= shamt_s;
                  kind_r   <= kind_s;
`endif
               end
            end
`ifndef EXEC_ALU_BARREL_SHIFT_EN
            ST_SHIFT: begin
               result_r <= shift_step(result_r, kind_r);
               cnt_r    <= cnt_r - CNT_ONE;
            end
`endif
            default: result_r <= result_r;
         endcase
      end
   end
endmodule

// File: tb/tb_exec_alu_seq.sv
// Self-checking bench for exec_alu_seq: directed scenarios plus random ops
// checked against an arithmetic reference model (result and latency).
module tb_exec_alu_seq;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
`ifdef EXEC_ALU_BARREL_SHIFT_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   exec_alu_seq_if bus ();
   exec_alu_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                             input logic [6:0] opc, input logic [2:0] f3, input logic f7);
      logic signed [31:0] sa;
      logic signed [31:0] sb;
      int sh;
      sa = a;
      sb = b;
      sh = int'(b[4:0]);
      if (opc == OPC_OP || opc == OPC_OP_IMM) begin
         case (f3)
            3'd0:    return (opc == OPC_OP && f7) ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7 ? 32'(sa >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
         endcase
      end else if (opc == OPC_LUI || opc == OPC_AUIPC) begin
         return a + b;
      end
      return 32'd0;
   endfunction

   function automatic int model_lat(input logic [31:0] b, input logic [6:0] opc, input logic [2:0] f3);
      if (!BARREL && (opc == OPC_OP || opc == OPC_OP_IMM) && (f3 == 3'd1 || f3 == 3'd5))
         return int'(b[4:0]) + 1;
      return 1;
   endfunction

   // Drives one operation, returns the delivered result and accept-to-valid latency.
   task automatic issue_op(input logic [31:0] a, input logic [31:0] b, input logic [6:0] opc,
                           input logic [2:0] f3, input logic f7, output logic [31:0] res, output int lat);
      int guard;
      guard = 0;
      while (!bus.in_ready && guard < 100) begin
         @(posedge clk); #1; guard++;
      end
      bus.A = a; bus.B = b; bus.opcode = opc; bus.funct3 = f3; bus.funct7_5 = f7;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.A = $urandom; bus.B = $urandom;
      bus.funct3 = 3'($urandom_range(0, 7)); bus.funct7_5 = 1'($urandom_range(0, 1));
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1; lat++;
      end
      res = bus.result;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      int stale;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.A = 32'd0; bus.B = 32'd0; bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_5 = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      // start SLL by 20, reset with 10 steps still to go
      bus.A = 32'h0000_00A5; bus.B = 32'd20; bus.opcode = OPC_OP; bus.funct3 = 3'd1; bus.funct7_5 = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      n_vec++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL midshift_reset_idle: in_ready=%b busy=%b want 1/0", bus.in_ready, bus.busy); end
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL midshift_reset_valid: got %b want 0", bus.out_valid); end
      n_vec++; if (bus.result !== 32'd0) begin n_err++; $display("FAIL midshift_reset_result: got %h want 0", bus.result); end
      stale = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus.out_valid !== 1'b0) stale++;
      end
      n_vec++; if (stale != 0) begin n_err++; $display("FAIL stale_output: %0d cycles valid, want 0", stale); end
   endtask

   task automatic test_add_sub();
      logic [31:0] res; int lat;
      issue_op(32'd5, 32'd7, OPC_OP, 3'd0, 1'b1, res, lat);
      n_vec++; if (res !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_result: got %h want fffffffe", res); end
      n_vec++; if (lat != 1) begin n_err++; $display("FAIL sub_latency: got %0d want 1", lat); end
      issue_op(32'd5, 32'd7, OPC_OP_IMM, 3'd0, 1'b1, res, lat);
      n_vec++; if (res !== 32'd12) begin n_err++; $display("FAIL addi_result: got %h want 0000000c", res); end
   endtask

   task automatic test_shift();
      logic [31:0] res; int lat;
      issue_op(32'h8000_0000, 32'h0000_0404, OPC_OP, 3'd5, 1'b1, res, lat);
      n_vec++; if (res !== 32'hF800_0000) begin n_err++; $display("FAIL sra_result: got %h want f8000000", res); end
      n_vec++; if (lat != (BARREL ? 1 : 5)) begin n_err++; $display("FAIL sra_latency: got %0d want %0d", lat, BARREL ? 1 : 5); end
      issue_op(32'h8000_0000, 32'h0000_0404, OPC_OP, 3'd5, 1'b0, res, lat);
      n_vec++; if (res !== 32'h0800_0000) begin n_err++; $display("FAIL srl_result: got %h want 08000000", res); end
      issue_op(32'd1, 32'hFFFF_FFE0, OPC_OP, 3'd1, 1'b0, res, lat);
      n_vec++; if (res !== 32'd1 || lat != 1) begin n_err++; $display("FAIL sll0: got %h lat %0d want 00000001 lat 1", res, lat); end
      issue_op(32'd1, 32'd31, OPC_OP_IMM, 3'd1, 1'b0, res, lat);
      n_vec++; if (res !== 32'h8000_0000) begin n_err++; $display("FAIL sll31_result: got %h want 80000000", res); end
      n_vec++; if (lat != (BARREL ? 1 : 32)) begin n_err++; $display("FAIL sll31_latency: got %0d want %0d", lat, BARREL ? 1 : 32); end
   endtask

   task automatic test_compare();
      logic [31:0] res; int lat;
      issue_op(32'hFFFF_FFFF, 32'd1, OPC_OP, 3'd2, 1'b0, res, lat);
      n_vec++; if (res !== 32'd1) begin n_err++; $display("FAIL slt: got %h want 00000001", res); end
      issue_op(32'hFFFF_FFFF, 32'd1, OPC_OP, 3'd3, 1'b0, res, lat);
      n_vec++; if (res !== 32'd0) begin n_err++; $display("FAIL sltu: got %h want 00000000", res); end
   endtask

   task automatic test_backpressure();
      logic [31:0] a, b, exp;
      int guard;
      a = $urandom; b = $urandom; exp = a ^ b;
      bus.A = a; bus.B = b; bus.opcode = OPC_OP; bus.funct3 = 3'd4; bus.funct7_5 = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      guard = 0;
      while (!bus.out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1; bus.A = $urandom; bus.B = $urandom;
         @(posedge clk); #1;
         n_vec++;
         if (bus.result !== exp || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hold_%0d: result=%h in_ready=%b out_valid=%b want %h/0/1", i, bus.result, bus.in_ready, bus.out_valid, exp);
         end
      end
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      n_vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL handoff_idle: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
      n_vec++; if (bus.result !== exp) begin n_err++; $display("FAIL handoff_result_kept: got %h want %h", bus.result, exp); end
      @(posedge clk); #1;
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL no_phantom_accept: got %b want 0", bus.out_valid); end
   endtask

   task automatic test_misc();
      logic [31:0] res; int lat;
      issue_op(32'h1234_5000, 32'd0, OPC_LUI, 3'($urandom_range(0, 7)), 1'b1, res, lat);
      n_vec++; if (res !== 32'h1234_5000) begin n_err++; $display("FAIL lui: got %h want 12345000", res); end
      issue_op(32'hDEAD_BEEF, 32'h1111_1111, OPC_LOAD, 3'd0, 1'b0, res, lat);
      n_vec++; if (res !== 32'd0 || lat != 1) begin n_err++; $display("FAIL other_opcode: got %h lat %0d want 00000000 lat 1", res, lat); end
   endtask

   task automatic test_random();
      logic [31:0] a, b, res;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      int          lat;
      for (int i = 0; i < 60; i++) begin
         a = $urandom; b = $urandom;
         f3 = 3'($urandom_range(0, 7)); f7 = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0, 1:    opc = OPC_OP;
            2:       opc = OPC_OP_IMM;
            3:       opc = OPC_LUI;
            4:       opc = OPC_AUIPC;
            default: opc = 7'($urandom_range(0, 127));
         endcase
         issue_op(a, b, opc, f3, f7, res, lat);
         n_vec++;
         if (res !== model_res(a, b, opc, f3, f7) || lat != model_lat(b, opc, f3)) begin
            n_err++;
            $display("FAIL random_%0d: opc=%b f3=%0d f7=%b A=%h B=%h got %h lat %0d want %h lat %0d",
                     i, opc, f3, f7, a, b, res, lat, model_res(a, b, opc, f3, f7), model_lat(b, opc, f3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_shift();
      test_compare();
      test_backpressure();
      test_misc();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
